bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Sequences all writes into the branch predictor tables: the BTB/bimodal table and the gshare table.
- After reset, or on a clear request, it sweeps every table index and writes a clear pattern, so the tables need no per-entry reset loops.
- In normal operation it buffers resolved branch/JAL updates from ROB commit in a small FIFO and drains one per cycle onto the tables' single write port.
- It sits between ROB commit and the predictor tables; fetch-side reads are unaffected.

Parameters:
- BTB_DEPTH_BITS, 7, index width of the BTB/bimodal table (sweep covers 2^BTB_DEPTH_BITS entries).
- GSHARE_DEPTH_BITS, GSHARE_DEPTH_BITS (package constant), gshare index width.
- Q_DEPTH, 4, update FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  committed branch/JAL update offered this cycle
- upd  in  bp_update_t  {pc[31:0], target[31:0], taken, is_branch, is_jal, gshare_idx}
- upd_ready  out  1  FIFO not full (informational; ROB never stalls on it)
- clear_req  in  1  single-cycle request to re-clear the tables (e.g. fence.i)
- tbl_stall  in  1  table write port busy this cycle
- wr_en  out  1  table write strobe
- wr_clear  out  1  write is an init/clear write, not an update
- wr_btb_idx  out  BTB_DEPTH_BITS  BTB/bimodal index
- wr_gs_idx  out  GSHARE_DEPTH_BITS  gshare index
- wr_data  out  bp_update_t  payload (all zeros when wr_clear=1)
- init_done  out  1  high in RUN state
- drop_cnt  out  16  saturating count of dropped updates

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- State while rst_n=0:
  - state=INIT, sweep counter=0, FIFO empty, drop_cnt=0.
  - Outputs: wr_en=0, wr_clear=0, init_done=0, upd_ready=1, wr_data=0, wr_btb_idx=0, wr_gs_idx=0.
- All write-port outputs are registered; nothing on them is combinational from the inputs.
- FSM states: INIT, RUN.
- INIT:
  - Every cycle with tbl_stall=0: drive wr_en=1, wr_clear=1, wr_btb_idx=cnt[BTB_DEPTH_BITS-1:0], wr_gs_idx=cnt[GSHARE_DEPTH_BITS-1:0], then increment cnt.
  - Sweep length is 2^max(BTB_DEPTH_BITS, GSHARE_DEPTH_BITS) writes.
  - After the last index is written, go to RUN and reset cnt to 0.
  - If tbl_stall=1: wr_en=0 and cnt holds.
  - The FIFO accepts enqueues during INIT but does not drain.
- RUN:
  - If the FIFO is non-empty and tbl_stall=0: pop the head and drive wr_en=1, wr_clear=0, wr_btb_idx=head.pc[BTB_DEPTH_BITS+1:2], wr_gs_idx=head.gshare_idx, wr_data=head.
  - Otherwise wr_en=0.
- clear_req in RUN: next state is INIT, cnt=0, FIFO flushed (stale history).
  - An update offered in the same cycle is discarded and counted in drop_cnt.
  - An entry popped in that cycle still completes its write.
- clear_req in INIT: restart the sweep at cnt=0. The FIFO is kept.
- Enqueue:
  - upd_ready=!full, from registered occupancy.
  - An update is enqueued when upd_valid && upd_ready.
  - An update with neither is_branch nor is_jal is ignored and not counted.
  - upd_valid && !upd_ready drops the update and increments drop_cnt, saturating at 16'hFFFF.
  - No bypass when full: a pop in the same cycle does not make room for that cycle's offer.
- Simultaneous enqueue and dequeue while non-full: both occur; occupancy is unchanged.
- Latency: an update enqueued in cycle N appears on the write port in cycle N+1 at the earliest (empty FIFO, RUN, no stall).
- FIFO pointers wrap modulo Q_DEPTH. Occupancy is log2(Q_DEPTH)+1 bits.
- Reset asserted mid-sweep or mid-drain: immediate return to the reset state; the sweep restarts from 0 after release.

Decomposition:
- rv32i_types package gains:
  - bp_update_t (packed struct above).
  - bp_sched_state_t enum {INIT, RUN}.
  - BP_UPD_Q_DEPTH constant.
- One sub-module, bp_update_fifo: parameterized synchronous FIFO with push, pop, full, empty and head. bp_update_sched holds the FSM, sweep counter, drop counter and output registers.

Test Plan:
- Reset release, tbl_stall=0 -> exactly 128 consecutive wr_en/wr_clear writes, wr_btb_idx 0..127, then init_done=1 and wr_en=0.
- RUN, empty FIFO, single update pc=0x0000_1008, taken=1 at cycle N -> cycle N+1: wr_en=1, wr_clear=0, wr_btb_idx=2, wr_data.pc=0x1008.
- tbl_stall held high, 5 back-to-back updates -> first 4 accepted, upd_ready=0 after the 4th, drop_cnt=1. Release stall -> 4 writes in FIFO order on consecutive cycles.
- clear_req with 3 entries queued and an update offered -> that cycle's pop still writes, FIFO empty, drop_cnt+1, then a full 128-entry sweep begins.
- tbl_stall toggled every other cycle during INIT -> sweep indices never skip or repeat; takes 256 cycles.
- rst_n pulsed low at sweep index 60 -> outputs return to reset values immediately; after release the sweep restarts at index 0.

Source files
------------

// File: rtl/bp_update_sched_pkg.sv
// Shared types and constants for the branch predictor update scheduler.
package bp_update_sched_pkg;

  localparam int unsigned GSHARE_DEPTH_BITS = 7;
  localparam int unsigned BP_UPD_Q_DEPTH    = 4;

  // Resolved branch/JAL update as committed by the ROB.
  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  target;
    logic                         taken;
    logic                         is_branch;
    logic                         is_jal;
    logic [GSHARE_DEPTH_BITS-1:0] gshare_idx;
  } bp_update_t;

  typedef enum logic {
    INIT,
    RUN
  } bp_sched_state_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO with flush; power-of-two depth, pointers wrap naturally.
module bp_update_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; flush discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + (PtrW+1)'(push_ok) - (PtrW+1)'(pop_ok);
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bp_update_sched.sv
// Serialises table-clear sweeps and committed branch updates onto the
// predictor tables' single write port.
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned BTB_DEPTH_BITS = 7,
  parameter int unsigned Q_DEPTH        = BP_UPD_Q_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd_valid,
  input  bp_update_t                   upd,
  output logic                         upd_ready,
  input  logic                         clear_req,
  input  logic                         tbl_stall,
  output logic                         wr_en,
  output logic                         wr_clear,
  output logic [BTB_DEPTH_BITS-1:0]    wr_btb_idx,
  output logic [GSHARE_DEPTH_BITS-1:0] wr_gs_idx,
  output bp_update_t                   wr_data,
  output logic                         init_done,
  output logic [15:0]                  drop_cnt
);

  localparam int unsigned CntW = (BTB_DEPTH_BITS > GSHARE_DEPTH_BITS) ?
                                 BTB_DEPTH_BITS : GSHARE_DEPTH_BITS;

  bp_sched_state_t             state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [15:0]                 drop_q, drop_d;
  logic                        wr_en_q, wr_en_d;
  logic                        wr_clear_q, wr_clear_d;
  logic [BTB_DEPTH_BITS-1:0]   wr_btb_q, wr_btb_d;
  logic [GSHARE_DEPTH_BITS-1:0] wr_gs_q, wr_gs_d;
  bp_update_t                  wr_data_q, wr_data_d;

  bp_update_t fifo_head;
  logic       fifo_full, fifo_empty;
  logic       fifo_push, fifo_pop, fifo_flush;
  logic       upd_ok, run, clr_run, bypass, drop;

  // Updates that are neither branch nor JAL never touch the tables.
  assign upd_ok     = upd_valid && (upd.is_branch || upd.is_jal);
  assign run        = (state_q == RUN);
  assign clr_run    = run && clear_req;
  assign fifo_pop   = run && !fifo_empty && !tbl_stall;
  // Empty queue in RUN: write the offer straight into the output registers.
  assign bypass     = run && !clear_req && !tbl_stall && fifo_empty && upd_ok;
  assign fifo_push  = upd_ok && !fifo_full && !clr_run && !bypass;
  assign drop       = upd_ok && (fifo_full || clr_run);
  assign fifo_flush = clr_run;

  bp_update_fifo #(
    .Width($bits(bp_update_t)),
    .Depth(Q_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(fifo_flush),
    .push (fifo_push),
    .wdata(upd),
    .pop  (fifo_pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Next-state: sweep sequencing, drain selection and drop counting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    wr_en_d    = 1'b0;
    wr_clear_d = 1'b0;
    wr_btb_d   = wr_btb_q;
    wr_gs_d    = wr_gs_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      INIT: begin
        if (clear_req) begin
          cnt_d = '0;
        end else if (!tbl_stall) begin
          wr_en_d    = 1'b1;
          wr_clear_d = 1'b1;
          wr_btb_d   = cnt_q[BTB_DEPTH_BITS-1:0];
          wr_gs_d    = cnt_q[GSHARE_DEPTH_BITS-1:0];
          wr_data_d  = '0;
          if (cnt_q == {CntW{1'b1}}) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      RUN: begin
        if (fifo_pop) begin
          wr_en_d   = 1'b1;
          wr_btb_d  = fifo_head.pc[BTB_DEPTH_BITS+1:2];
          wr_gs_d   = fifo_head.gshare_idx;
          wr_data_d = fifo_head;
        end else if (bypass) begin
          wr_en_d   = 1'b1;
          wr_btb_d  = upd.pc[BTB_DEPTH_BITS+1:2];
          wr_gs_d   = upd.gshare_idx;
          wr_data_d = upd;
        end
        if (clear_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase

    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      drop_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_clear_q <= 1'b0;
      wr_btb_q   <= '0;
      wr_gs_q    <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      wr_en_q    <= wr_en_d;
      wr_clear_q <= wr_clear_d;
      wr_btb_q   <= wr_btb_d;
      wr_gs_q    <= wr_gs_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign upd_ready  = !fifo_full;
  assign wr_en      = wr_en_q;
  assign wr_clear   = wr_clear_q;
  assign wr_btb_idx = wr_btb_q;
  assign wr_gs_idx  = wr_gs_q;
  assign wr_data    = wr_data_q;
  assign init_done  = run;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed self-checking bench for bp_update_sched.
module tb_bp_update_sched;
  import bp_update_sched_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         upd_valid;
  bp_update_t                   upd;
  logic                         upd_ready;
  logic                         clear_req;
  logic                         tbl_stall;
  logic                         wr_en;
  logic                         wr_clear;
  logic [6:0]                   wr_btb_idx;
  logic [GSHARE_DEPTH_BITS-1:0] wr_gs_idx;
  bp_update_t                   wr_data;
  logic                         init_done;
  logic [15:0]                  drop_cnt;

  int passed = 0;
  int total  = 0;

  bp_update_sched #(
    .BTB_DEPTH_BITS(7),
    .Q_DEPTH       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd       (upd),
    .upd_ready (upd_ready),
    .clear_req (clear_req),
    .tbl_stall (tbl_stall),
    .wr_en     (wr_en),
    .wr_clear  (wr_clear),
    .wr_btb_idx(wr_btb_idx),
    .wr_gs_idx (wr_gs_idx),
    .wr_data   (wr_data),
    .init_done (init_done),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bp_update_t mk_upd(input logic [31:0] pc, input logic [6:0] gs);
    bp_update_t u;
    u.pc         = pc;
    u.target     = pc + 32'd8;
    u.taken      = 1'b1;
    u.is_branch  = 1'b1;
    u.is_jal     = 1'b0;
    u.gshare_idx = gs;
    return u;
  endfunction

  // Step until init_done, checking that clear writes cover 0..127 in order.
  task automatic run_sweep(input bit toggle, output int n, output int bad, output int cycles);
    n      = 0;
    bad    = 0;
    cycles = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tbl_stall = toggle ? ~cyc[0] : 1'b0;
      step();
      if (wr_en) begin
        if (wr_clear && wr_btb_idx == 7'(n) && wr_gs_idx == 7'(n) && wr_data == '0) n++;
        else bad++;
      end
      if (init_done) begin
        cycles = cyc + 1;
        break;
      end
    end
    tbl_stall = 1'b0;
  endtask

  initial begin
    int n, bad, cycles;
    bit found;

    rst_n     = 1'b0;
    upd_valid = 1'b0;
    upd       = '0;
    clear_req = 1'b0;
    tbl_stall = 1'b0;
    #1;
    step();
    step();
    check_eq("rst_wr_en",     64'(wr_en), 64'd0);
    check_eq("rst_wr_clear",  64'(wr_clear), 64'd0);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    check_eq("rst_upd_ready", 64'(upd_ready), 64'd1);
    check_eq("rst_drop_cnt",  64'(drop_cnt), 64'd0);
    check_eq("rst_btb_idx",   64'(wr_btb_idx), 64'd0);
    check_eq("rst_wr_data",   64'(wr_data.pc), 64'd0);

    // Initial sweep after reset release.
    rst_n = 1'b1;
    run_sweep(1'b0, n, bad, cycles);
    check_eq("sweep0_writes", 64'(n), 64'd128);
    check_eq("sweep0_bad",    64'(bad), 64'd0);
    check_eq("sweep0_cycles", 64'(cycles), 64'd128);
    step();
    check_eq("sweep0_idle_wr_en", 64'(wr_en), 64'd0);
    check_eq("sweep0_init_done",  64'(init_done), 64'd1);

    // Single update, empty FIFO: visible the cycle after the offer.
    upd_valid = 1'b1;
    upd       = mk_upd(32'h0000_1008, 7'd5);
    step();
    upd_valid = 1'b0;
    check_eq("single_wr_en",    64'(wr_en), 64'd1);
    check_eq("single_wr_clear", 64'(wr_clear), 64'd0);
    check_eq("single_btb_idx",  64'(wr_btb_idx), 64'd2);
    check_eq("single_gs_idx",   64'(wr_gs_idx), 64'd5);
    check_eq("single_pc",       64'(wr_data.pc), 64'h1008);
    check_eq("single_target",   64'(wr_data.target), 64'h1010);
    step();
    check_eq("single_after_wr_en", 64'(wr_en), 64'd0);

    // Neither branch nor JAL: ignored, not counted.
    upd_valid = 1'b1;
    upd       = mk_upd(32'h0000_2000, 7'd1);
    upd.is_branch = 1'b0;
    step();
    upd_valid = 1'b0;
    check_eq("ignored_wr_en", 64'(wr_en), 64'd0);
    check_eq("ignored_drop",  64'(drop_cnt), 64'd0);

    // Stalled port: 4 accepted, 5th dropped, then drained in order.
    tbl_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1;
      upd       = mk_upd(32'h100 + 32'(i * 4), 7'(i));
      step();
      if (i == 2) check_eq("stall_ready_3", 64'(upd_ready), 64'd1);
      if (i == 3) check_eq("stall_ready_4", 64'(upd_ready), 64'd0);
    end
    upd_valid = 1'b0;
    check_eq("stall_wr_en",    64'(wr_en), 64'd0);
    check_eq("stall_drop_cnt", 64'(drop_cnt), 64'd1);
    tbl_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("drain_wr_en",   64'(wr_en), 64'd1);
      check_eq("drain_pc",      64'(wr_data.pc), 64'h100 + 64'(i * 4));
      check_eq("drain_btb_idx", 64'(wr_btb_idx), 64'd64 + 64'(i));
      check_eq("drain_gs_idx",  64'(wr_gs_idx), 64'(i));
    end
    step();
    check_eq("drain_done_wr_en",  64'(wr_en), 64'd0);
    check_eq("drain_done_ready",  64'(upd_ready), 64'd1);

    // clear_req with 3 queued and an offer in the same cycle.
    tbl_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd       = mk_upd(32'h200 + 32'(i * 4), 7'd9);
      step();
    end
    tbl_stall = 1'b0;
    clear_req = 1'b1;
    upd       = mk_upd(32'h300, 7'd3);
    step();
    clear_req = 1'b0;
    upd_valid = 1'b0;
    check_eq("clr_pop_wr_en",    64'(wr_en), 64'd1);
    check_eq("clr_pop_wr_clear", 64'(wr_clear), 64'd0);
    check_eq("clr_pop_pc",       64'(wr_data.pc), 64'h200);
    check_eq("clr_init_done",    64'(init_done), 64'd0);
    check_eq("clr_drop_cnt",     64'(drop_cnt), 64'd2);
    check_eq("clr_upd_ready",    64'(upd_ready), 64'd1);
    run_sweep(1'b0, n, bad, cycles);
    check_eq("sweep1_writes", 64'(n), 64'd128);
    check_eq("sweep1_bad",    64'(bad), 64'd0);
    check_eq("sweep1_cycles", 64'(cycles), 64'd128);
    step();
    check_eq("sweep1_fifo_flushed", 64'(wr_en), 64'd0);

    // Sweep with tbl_stall toggling every other cycle.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check_eq("clr2_wr_en", 64'(wr_en), 64'd0);
    run_sweep(1'b1, n, bad, cycles);
    check_eq("sweep2_writes", 64'(n), 64'd128);
    check_eq("sweep2_bad",    64'(bad), 64'd0);
    check_eq("sweep2_cycles", 64'(cycles), 64'd256);
    step();
    check_eq("sweep2_idle_wr_en", 64'(wr_en), 64'd0);

    // Reset pulse in the middle of a sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (wr_en && wr_btb_idx == 7'd60) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mid_reach_idx60", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wr_en",     64'(wr_en), 64'd0);
    check_eq("mid_rst_wr_clear",  64'(wr_clear), 64'd0);
    check_eq("mid_rst_btb_idx",   64'(wr_btb_idx), 64'd0);
    check_eq("mid_rst_init_done", 64'(init_done), 64'd0);
    check_eq("mid_rst_drop_cnt",  64'(drop_cnt), 64'd0);
    check_eq("mid_rst_upd_ready", 64'(upd_ready), 64'd1);
    step();
    rst_n = 1'b1;
    run_sweep(1'b0, n, bad, cycles);
    check_eq("sweep3_writes", 64'(n), 64'd128);
    check_eq("sweep3_bad",    64'(bad), 64'd0);
    check_eq("sweep3_cycles", 64'(cycles), 64'd128);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
